// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and widths for the two-master Wishbone arbiter
package wb_arb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  function automatic int outst_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - counts silent cycles with transfers pending and flags a hang
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic busy,
  input  logic resp,
  input  logic clear,
  output logic fire
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q;

  // A response in the firing cycle wins, so resp masks fire.
  assign fire = busy & ~resp & (wdog_q == LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wdog_q <= '0;
    end else if (clear | fire | ~busy | resp) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 16'd1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - round-robin two-master to one-slave pipelined Wishbone arbiter
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTST      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  output logic                m0_stall_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  output logic                m1_stall_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  input  logic                s_stall_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  output logic                timeout_o
);

  localparam int            OW  = outst_width(MAX_OUTST);
  localparam logic [OW-1:0] CAP = OW'(MAX_OUTST);

  arb_state_e    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [OW-1:0] outst_q, outst_d;

  logic granted, gnt1, leaving, room, full, busy;
  logic x_cyc, x_stb, x_we;
  logic [WB_ADR_W-1:0] x_adr;
  logic [WB_DAT_W-1:0] x_dat;
  logic [WB_SEL_W-1:0] x_sel;
  logic fwd_ack, fwd_err, accept, retire, fire;

  assign granted = (state_q != ST_IDLE);
  assign gnt1    = (state_q == ST_GNT1);
  assign x_cyc   = gnt1 ? m1_cyc_i : m0_cyc_i;
  assign x_stb   = gnt1 ? m1_stb_i : m0_stb_i;
  assign x_we    = gnt1 ? m1_we_i  : m0_we_i;
  assign x_adr   = gnt1 ? m1_adr_i : m0_adr_i;
  assign x_dat   = gnt1 ? m1_dat_i : m0_dat_i;
  assign x_sel   = gnt1 ? m1_sel_i : m0_sel_i;

  assign leaving = granted & ~x_cyc;
  assign room    = (outst_q < CAP);
  assign full    = (outst_q == CAP);
  // Slave responses with nothing outstanding are stray and never forwarded.
  assign busy    = granted & (outst_q != '0);
  assign fwd_ack = busy & s_ack_i;
  assign fwd_err = busy & s_err_i;
  assign accept  = s_stb_o & ~s_stall_i;
  assign retire  = fwd_ack | fwd_err;
  assign timeout_o = fire;

  wb_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .busy      (busy),
    .resp      (s_ack_i | s_err_i),
    .clear     (~granted | leaving),
    .fire      (fire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      outst_q      <= outst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i | m1_cyc_i) begin
          last_grant_d = (m0_cyc_i & m1_cyc_i) ? ~last_grant_q : m1_cyc_i;
          state_d      = last_grant_d ? ST_GNT1 : ST_GNT0;
        end
      end
      default: begin
        if (!x_cyc) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (!granted || leaving || fire) begin
      outst_d = '0;
    end else if (accept && !retire) begin
      outst_d = outst_q + 1'b1;
    end else if (!accept && retire) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_dat_o   = '0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_dat_o   = '0;
    if (granted) begin
      s_cyc_o = x_cyc;
      s_stb_o = x_stb & room;
      s_we_o  = x_we;
      s_adr_o = x_adr;
      s_dat_o = x_dat;
      s_sel_o = x_sel;
      if (gnt1) begin
        m1_stall_o = s_stall_i | full;
        m1_ack_o   = fwd_ack;
        m1_err_o   = fwd_err | fire;
        m1_dat_o   = s_dat_i;
      end else begin
        m0_stall_o = s_stall_i | full;
        m0_ack_o   = fwd_ack;
        m0_err_o   = fwd_err | fire;
        m0_dat_o   = s_dat_i;
      end
    end
  end

endmodule
